// File: rtl/calc_token_encoder.sv
// Token stream encoder for the 8-bit calculator. A FIFO holds (op, operand) entries and
// replays them on go as operand, op, operand, ..., EQL with one token per clock.
module calc_token_encoder #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          push_op,
  input  logic [7:0]    push_val,
  input  logic          go,
  output logic [7:0]    tok,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count,
  output logic          err,
  output logic          overflow,
  output logic [1:0]    dbg_state
);

  // dbg_state mirrors r_state: tok content for the current cycle is implied by it.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NUM  = 2'd1;
  localparam logic [1:0] S_OP   = 2'd2;
  localparam logic [1:0] S_EQL  = 2'd3;

  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  localparam logic [7:0] TOK_ADD = 8'd0;
  localparam logic [7:0] TOK_EQL = 8'd2;
  localparam logic [7:0] TOK_CLR = 8'd3;

  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [1:0]    r_state;
  logic [7:0]    r_tok;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          r_overflow;

  logic [8:0]    w_head;
  logic [7:0]    w_head_val;
  logic          w_head_op;
  logic          w_empty;
  logic          w_full;
  logic          w_head_ok;
  logic          w_wr_en;

  assign w_head     = r_mem[r_rd_ptr];
  assign w_head_val = w_head[7:0];
  assign w_head_op  = w_head[8];
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == L_FULL);
  assign w_head_ok  = (w_head_val > TOK_CLR);
  assign w_wr_en    = (r_state == S_IDLE) && push && !w_full;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= {push_op, push_val};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_state    <= S_IDLE;
      r_tok      <= TOK_CLR;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tok  <= TOK_CLR;
          r_busy <= 1'b0;
          if (push) begin
            if (w_full) begin
              r_overflow <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
              r_count  <= r_count + 1'b1;
            end
          end else if (go && !w_empty) begin
            r_overflow <= 1'b0;
            if (w_head_ok) begin
              r_err    <= 1'b0;
              r_tok    <= w_head_val;
              r_rd_ptr <= r_rd_ptr + 1'b1;
              r_count  <= r_count - 1'b1;
              r_busy   <= 1'b1;
              r_state  <= S_NUM;
            end else begin
              // Bad first operand: nothing but the idle CLR goes out.
              r_err    <= 1'b1;
              r_rd_ptr <= r_wr_ptr;
              r_count  <= '0;
              r_done   <= 1'b1;
            end
          end
        end
        S_NUM: begin
          r_busy <= 1'b1;
          if (w_empty) begin
            r_tok   <= TOK_EQL;
            r_state <= S_EQL;
          end else begin
            r_tok   <= TOK_ADD | {7'd0, w_head_op};
            r_state <= S_OP;
          end
        end
        S_OP: begin
          if (w_head_ok) begin
            r_tok    <= w_head_val;
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count  <= r_count - 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_NUM;
          end else begin
            r_tok    <= TOK_CLR;
            r_err    <= 1'b1;
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        S_EQL: begin
          r_tok   <= TOK_CLR;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_tok   <= TOK_CLR;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tok       = r_tok;
  assign busy      = r_busy;
  assign done      = r_done;
  assign count     = r_count;
  assign err       = r_err;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_calc_token_encoder.sv
// Bench for calc_token_encoder: directed cases plus random expressions, each checked
// against a queue-based model of the token stream the expression should produce.
module tb_calc_token_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       push = 1'b0;
  logic       push_op = 1'b0;
  logic [7:0] push_val = 8'd0;
  logic       go = 1'b0;
  logic [7:0] tok;
  logic       busy;
  logic       done;
  logic [3:0] count;
  logic       err;
  logic       overflow;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;

  logic [8:0] model_q[$];
  logic [7:0] exp_q[$];
  bit         exp_abort;

  calc_token_encoder #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset(reset), .push(push), .push_op(push_op), .push_val(push_val),
    .go(go), .tok(tok), .busy(busy), .done(done), .count(count), .err(err),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_entry(input logic op, input logic [7:0] val);
    push = 1'b1; push_op = op; push_val = val;
    tick();
    push = 1'b0;
    if (model_q.size() < 8) model_q.push_back({op, val});
  endtask

  // Expected tokens while busy, derived from the entry list alone.
  function automatic void build_expected();
    exp_q.delete();
    exp_abort = 1'b0;
    for (int i = 0; i < model_q.size(); i++) begin
      if (i > 0) exp_q.push_back({7'd0, model_q[i][8]});
      if (model_q[i][7:0] <= 8'd3) begin
        exp_abort = 1'b1;
        break;
      end
      exp_q.push_back(model_q[i][7:0]);
    end
    if (!exp_abort) exp_q.push_back(8'd2);
    model_q.delete();
  endfunction

  task automatic run_stream(input string name, input bit push_during);
    build_expected();
    go = 1'b1;
    tick();
    go = 1'b0;
    push = push_during; push_val = 8'd50;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ({tok, busy} !== {exp_q[i], 1'b1}) begin
        errors++;
        $display("FAIL %s tok[%0d]: got tok=%0d busy=%0b, want tok=%0d busy=1",
                 name, i, tok, busy, exp_q[i]);
      end
      tick();
    end
    push = 1'b0;
    checks++;
    if ({tok, busy, done, err, overflow, count} !== {8'd3, 1'b0, 1'b1, exp_abort, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL %s end: got tok=%0d busy=%0b done=%0b err=%0b ovf=%0b count=%0d, want tok=3 busy=0 done=1 err=%0b ovf=0 count=0",
               name, tok, busy, done, err, overflow, count, exp_abort);
    end
    tick();
    checks++;
    if ({done, tok, busy} !== {1'b0, 8'd3, 1'b0}) begin
      errors++;
      $display("FAIL %s post: got done=%0b tok=%0d busy=%0b, want done=0 tok=3 busy=0",
               name, done, tok, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({tok, busy, done, count, err, overflow, dbg_state} !== {8'd3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset: got tok=%0d busy=%0b done=%0b count=%0d err=%0b ovf=%0b st=%0d, want 3/0/0/0/0/0/0",
               tok, busy, done, count, err, overflow, dbg_state);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    push_entry(1'b0, 8'd10);
    push_entry(1'b0, 8'd20);
    checks++;
    if (count !== 4'd2) begin
      errors++;
      $display("FAIL case1 count: got %0d want 2", count);
    end
    run_stream("case1", 1'b0);
    push_entry(1'b0, 8'd100);
    push_entry(1'b1, 8'd40);
    push_entry(1'b0, 8'd5);
    run_stream("case2", 1'b0);
  endtask

  task automatic test_abort();
    push_entry(1'b0, 8'd50);
    push_entry(1'b0, 8'd2);
    push_entry(1'b0, 8'd9);
    run_stream("abort_op", 1'b0);
    push_entry(1'b0, 8'd2);
    push_entry(1'b1, 8'd30);
    run_stream("abort_first", 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) push_entry(1'($urandom_range(0, 1)), 8'($urandom_range(4, 255)));
    checks++;
    if ({overflow, count} !== {1'b1, 4'd8}) begin
      errors++;
      $display("FAIL overflow: got ovf=%0b count=%0d want ovf=1 count=8", overflow, count);
    end
    run_stream("overflow_stream", 1'b0);
  endtask

  task automatic test_ignored();
    go = 1'b1;
    tick();
    go = 1'b0;
    checks++;
    if ({tok, busy, done} !== {8'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL go_empty: got tok=%0d busy=%0b done=%0b want 3/0/0", tok, busy, done);
    end
    push = 1'b1; go = 1'b1; push_op = 1'b0; push_val = 8'd77;
    tick();
    push = 1'b0; go = 1'b0;
    model_q.push_back({1'b0, 8'd77});
    tick();
    checks++;
    if ({count, busy, tok} !== {4'd1, 1'b0, 8'd3}) begin
      errors++;
      $display("FAIL push_go: got count=%0d busy=%0b tok=%0d want 1/0/3", count, busy, tok);
    end
    push_entry(1'b1, 8'd33);
    run_stream("push_during_busy", 1'b1);
  endtask

  task automatic test_reset_mid();
    push_entry(1'b0, 8'd100);
    push_entry(1'b1, 8'd40);
    push_entry(1'b0, 8'd5);
    model_q.delete();
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    checks++;
    if (tok !== 8'd40) begin
      errors++;
      $display("FAIL mid_tok3: got %0d want 40", tok);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({tok, busy, count, err, done} !== {8'd3, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got tok=%0d busy=%0b count=%0d err=%0b done=%0b want 3/0/0/0/0",
               tok, busy, count, err, done);
    end
    tick();
    checks++;
    if ({tok, busy, done} !== {8'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_after: got tok=%0d busy=%0b done=%0b want 3/0/0", tok, busy, done);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int n;
      n = $urandom_range(1, 9);
      for (int k = 0; k < n; k++) begin
        logic [7:0] v;
        v = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(4, 255));
        push_entry(1'($urandom_range(0, 1)), v);
      end
      run_stream($sformatf("rand%0d", it), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_overflow();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
